// File: rtl/avr_timer_pkg.sv
// avr_timer_pkg: register addresses, control/status bit positions, clock-select
// encodings and prescaler tap positions shared by the avr_io_timer_cmp files.
package avr_timer_pkg;

  // I/O register addresses on the 3-bit peripheral address bus
  localparam logic [2:0] ADR_TCNTL = 3'd0;
  localparam logic [2:0] ADR_TTMP  = 3'd1;
  localparam logic [2:0] ADR_TCR   = 3'd2;
  localparam logic [2:0] ADR_TSR   = 3'd3;
  localparam logic [2:0] ADR_OCR0L = 3'd4;
  localparam logic [2:0] ADR_OCR1L = 3'd5;

  // TCR bit positions; bits [2:0] hold the clock select
  localparam int TCR_CTC   = 3;
  localparam int TCR_PWMEN = 4;
  localparam int TCR_OCIE1 = 5;
  localparam int TCR_OCIE0 = 6;
  localparam int TCR_TOIE  = 7;

  // TSR bit positions; the remaining bits read as 0
  localparam int TSR_TOV  = 7;
  localparam int TSR_OCF0 = 6;
  localparam int TSR_OCF1 = 5;

  // Clock-select encodings; codes 101-111 behave as stop
  typedef enum logic [2:0] {
    CS_STOP    = 3'b000,
    CS_CLK     = 3'b001,
    CS_DIV16   = 3'b010,
    CS_DIV256  = 3'b011,
    CS_DIV4096 = 3'b100
  } cs_e;

  // Prescaler bits whose falling edge produces the divided ticks
  localparam int TAP_DIV16   = 3;
  localparam int TAP_DIV256  = 7;
  localparam int TAP_DIV4096 = 11;

  // Address of the low-byte register of compare channel k
  function automatic logic [2:0] ocr_addr(input int k);
    return (k == 0) ? ADR_OCR0L : ADR_OCR1L;
  endfunction

endpackage

// File: rtl/avr_timer_prescaler.sv
// avr_timer_prescaler: free-running prescaler producing the timer tick for the
// selected clock source. A synchronous clear restarts the division so the
// first divided tick after a counter load comes a full period later.
module avr_timer_prescaler
  import avr_timer_pkg::*;
#(
  parameter int PRE_W = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic [2:0] cs,
  output logic       tick
);

  logic [PRE_W-1:0] cnt_q, cnt_d;
  logic [2:0]       tap_q, tap_d;
  logic [2:0]       tap_now;
  logic [2:0]       tap_fall;

  assign tap_now  = {cnt_q[TAP_DIV4096], cnt_q[TAP_DIV256], cnt_q[TAP_DIV16]};
  assign tap_fall = tap_q & ~tap_now;

  // Next counter value and previous-tap snapshot, both zeroed by clear
  always_comb begin
    cnt_d = cnt_q + PRE_W'(1);
    tap_d = tap_now;
    if (clr) begin
      cnt_d = '0;
      tap_d = '0;
    end
  end

  // Counter and previous-tap registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      tap_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      tap_q <= tap_d;
    end
  end

  // Select the tick source: every cycle, or a falling edge of one tap
  always_comb begin
    tick = 1'b0;
    case (cs_e'(cs))
      CS_STOP:    tick = 1'b0;
      CS_CLK:     tick = 1'b1;
      CS_DIV16:   tick = tap_fall[0];
      CS_DIV256:  tick = tap_fall[1];
      CS_DIV4096: tick = tap_fall[2];
      default:    tick = 1'b0;
    endcase
  end

endmodule

// File: rtl/avr_io_timer_cmp.sv
// avr_io_timer_cmp: 16-bit timer/counter on the 8-bit AVR I/O bus with NCH
// output-compare channels, clear-on-compare mode, write-1-to-clear flags and
// one interrupt line. 16-bit registers are accessed through the TTMP byte.
// Build option AVR_TIMER_PWM_EN: when defined, registered PWM outputs are
// built; otherwise pwm is tied to 0 and TCR.PWMEN is a plain storage bit.
module avr_io_timer_cmp
  import avr_timer_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int PRE_W = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           io_re,
  input  logic           io_we,
  input  logic [2:0]     io_a,
  output logic [7:0]     io_do,
  input  logic [7:0]     io_di,
  output logic           irq,
  output logic [NCH-1:0] pwm
);

  logic [15:0]    tcnt_q, tcnt_d;
  logic [7:0]     ttmp_q, ttmp_d;
  logic [7:0]     tcr_q, tcr_d;
  logic           tov_q, tov_d;
  logic [NCH-1:0] ocf_q, ocf_d;
  logic [15:0]    ocr_q [NCH];
  logic [15:0]    ocr_d [NCH];

  logic           wr;
  logic           commit;
  logic           tick;
  logic [1:0]     ocf_ext;
  logic [1:0]     ocf_clr;
  logic [1:0]     ocie;

  // A read in the same cycle wins over a write; a TCNTL write is a commit
  assign wr      = io_we & ~io_re;
  assign commit  = wr & (io_a == ADR_TCNTL);
  assign ocf_ext = 2'(ocf_q);
  assign ocf_clr = {io_di[TSR_OCF1], io_di[TSR_OCF0]};
  assign ocie    = {tcr_q[TCR_OCIE1], tcr_q[TCR_OCIE0]};

  avr_timer_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (commit),
    .cs   (tcr_q[2:0]),
    .tick (tick)
  );

  // Next-state logic: read-side TTMP latching, bus writes, then counting
  always_comb begin
    tcnt_d = tcnt_q;
    ttmp_d = ttmp_q;
    tcr_d  = tcr_q;
    tov_d  = tov_q;
    ocf_d  = ocf_q;
    ocr_d  = ocr_q;

    if (io_re) begin
      if (io_a == ADR_TCNTL) ttmp_d = tcnt_q[15:8];
      for (int k = 0; k < NCH; k++) begin
        if (io_a == ocr_addr(k)) ttmp_d = ocr_q[k][15:8];
      end
    end

    if (wr) begin
      case (io_a)
        ADR_TCNTL: tcnt_d = {ttmp_q, io_di};
        ADR_TTMP:  ttmp_d = io_di;
        ADR_TCR:   tcr_d  = io_di;
        ADR_TSR: begin
          tov_d = tov_q & ~io_di[TSR_TOV];
          for (int k = 0; k < NCH; k++) ocf_d[k] = ocf_q[k] & ~ocf_clr[k];
        end
        default: begin
          for (int k = 0; k < NCH; k++) begin
            if (io_a == ocr_addr(k)) ocr_d[k] = {ttmp_q, io_di};
          end
        end
      endcase
    end

    // Flag sets come after the clears so a same-cycle event keeps its flag
    if (tick && !commit) begin
      for (int k = 0; k < NCH; k++) begin
        if (tcnt_q == ocr_q[k]) ocf_d[k] = 1'b1;
      end
      if (tcr_q[TCR_CTC] && (tcnt_q == ocr_q[0])) begin
        tcnt_d = 16'h0000;
      end else begin
        tcnt_d = tcnt_q + 16'd1;
        if (tcnt_q == 16'hFFFF) tov_d = 1'b1;
      end
    end
  end

  // Timer state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_q <= 16'h0000;
      ttmp_q <= 8'h00;
      tcr_q  <= 8'h00;
      tov_q  <= 1'b0;
      ocf_q  <= '0;
      for (int k = 0; k < NCH; k++) ocr_q[k] <= 16'hFFFF;
    end else begin
      tcnt_q <= tcnt_d;
      ttmp_q <= ttmp_d;
      tcr_q  <= tcr_d;
      tov_q  <= tov_d;
      ocf_q  <= ocf_d;
      ocr_q  <= ocr_d;
    end
  end

  // Combinational read mux; unused addresses and idle cycles return 0
  always_comb begin
    io_do = 8'h00;
    if (io_re) begin
      case (io_a)
        ADR_TCNTL: io_do = tcnt_q[7:0];
        ADR_TTMP:  io_do = ttmp_q;
        ADR_TCR:   io_do = tcr_q;
        ADR_TSR:   io_do = {tov_q, ocf_ext[0], ocf_ext[1], 5'b00000};
        default: begin
          for (int k = 0; k < NCH; k++) begin
            if (io_a == ocr_addr(k)) io_do = ocr_q[k][7:0];
          end
        end
      endcase
    end
  end

  // Interrupt request: any status flag whose enable is set
  always_comb begin
    irq = (tov_q & tcr_q[TCR_TOIE]) | (|(ocf_ext & ocie));
  end

`ifdef AVR_TIMER_PWM_EN
  logic [NCH-1:0] pwm_q, pwm_d;

  // Each PWM output is high while the count is below its compare value
  always_comb begin
    pwm_d = '0;
    for (int k = 0; k < NCH; k++) begin
      pwm_d[k] = tcr_q[TCR_PWMEN] & (tcnt_q < ocr_q[k]);
    end
  end

  // PWM output registers
  always_ff @(posedge clk) begin
    if (rst) pwm_q <= '0;
    else     pwm_q <= pwm_d;
  end

  assign pwm = pwm_q;
`else
  assign pwm = '0;
`endif

endmodule
